// File: rtl/bumpy_state_ctrl_if.sv
// Bus for the bumpy movement controller: game/key/collision requests in,
// movement command and lives status out.
interface bumpy_state_ctrl_if;
  logic       game_start;
  logic       key_left;
  logic       key_right;
  logic       key_up;
  logic       key_down;
  logic       coll_left;
  logic       coll_right;
  logic       coll_top;
  logic       coll_hazard;
  logic [3:0] state;
  logic [2:0] lives;
  logic       game_over;

  modport master (
    output game_start, key_left, key_right, key_up, key_down,
    output coll_left, coll_right, coll_top, coll_hazard,
    input  state, lives, game_over
  );

  modport slave (
    input  game_start, key_left, key_right, key_up, key_down,
    input  coll_left, coll_right, coll_top, coll_hazard,
    output state, lives, game_over
  );
endinterface

// File: rtl/bumpy_state_ctrl.sv
// Frame-paced movement FSM for the bumpy sprite: keys, wall bounces, death and lives.
// Define BUMPY_CTRL_LIVES_EN to enable lives counting and game-over handling.
module bumpy_state_ctrl #(
  parameter int unsigned BOUNCE_FRAMES = 8,
  parameter int unsigned DASH_FRAMES   = 16,
  parameter int unsigned DIE_FRAMES    = 30,
  parameter int unsigned INIT_LIVES    = 3
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               startOfFrame,
  bumpy_state_ctrl_if.slave  bus
);

  localparam int unsigned MAX_AB     = (BOUNCE_FRAMES > DASH_FRAMES) ? BOUNCE_FRAMES : DASH_FRAMES;
  localparam int unsigned MAX_FRAMES = (MAX_AB > DIE_FRAMES) ? MAX_AB : DIE_FRAMES;
  localparam int unsigned CNT_RAW    = $clog2(MAX_FRAMES + 1);
  localparam int unsigned CNT_W      = (CNT_RAW < 5) ? 5 : CNT_RAW;

  typedef enum logic [3:0] {
    S_RESET        = 4'd0,
    S_IDLE         = 4'd1,
    S_LEFT         = 4'd2,
    S_RIGHT        = 4'd3,
    S_DOWN         = 4'd4,
    S_UP           = 4'd5,
    S_DIE          = 4'd6,
    S_BOUNCE_LEFT  = 4'd7,
    S_BOUNCE_RIGHT = 4'd8,
    S_BOUNCE_TOP   = 4'd9
  } state_t;

  state_t             state_q;
  logic [CNT_W-1:0]   frame_cnt;
  logic [CNT_W-1:0]   limit_m1;
  logic               sticky_left, sticky_right, sticky_top, sticky_hazard;
  logic               start_q;
  logic               eff_left, eff_right, eff_top, eff_hazard, eff_wall, eff_start;
  logic               start_ok, frame_last, in_bounce;
  logic               lives_left, game_over_w;

`ifdef BUMPY_CTRL_LIVES_EN
  logic [2:0] lives_q;
  logic       game_over_q;
  assign lives_left  = (lives_q != 3'd0);
  assign game_over_w = game_over_q;
  assign bus.lives     = lives_q;
  assign bus.game_over = game_over_q;
`else
  assign lives_left  = 1'b1;
  assign game_over_w = 1'b0;
  assign bus.lives     = 3'(INIT_LIVES);
  assign bus.game_over = 1'b0;
`endif

  assign bus.state = state_q;

  // A collision on the startOfFrame clk itself still counts for this frame.
  always_comb begin
    eff_left   = sticky_left   | bus.coll_left;
    eff_right  = sticky_right  | bus.coll_right;
    eff_top    = sticky_top    | bus.coll_top;
    eff_hazard = sticky_hazard | bus.coll_hazard;
    eff_wall   = eff_left | eff_right | eff_top;
    start_ok   = (state_q == S_RESET) || game_over_w;
    eff_start  = start_q | (bus.game_start & start_ok);
    in_bounce  = (state_q == S_BOUNCE_LEFT) || (state_q == S_BOUNCE_RIGHT) ||
                 (state_q == S_BOUNCE_TOP);
  end

  always_comb begin
    limit_m1 = '0;
    case (state_q)
      S_UP, S_DOWN:                               limit_m1 = CNT_W'(DASH_FRAMES - 1);
      S_DIE:                                      limit_m1 = CNT_W'(DIE_FRAMES - 1);
      S_BOUNCE_LEFT, S_BOUNCE_RIGHT, S_BOUNCE_TOP: limit_m1 = CNT_W'(BOUNCE_FRAMES - 1);
      default:                                    limit_m1 = '0;
    endcase
    frame_last = (frame_cnt == limit_m1);
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q       <= S_RESET;
      frame_cnt     <= '0;
      sticky_left   <= 1'b0;
      sticky_right  <= 1'b0;
      sticky_top    <= 1'b0;
      sticky_hazard <= 1'b0;
      start_q       <= 1'b0;
`ifdef BUMPY_CTRL_LIVES_EN
      lives_q       <= 3'(INIT_LIVES);
      game_over_q   <= 1'b0;
`endif
    end else if (startOfFrame) begin
      sticky_left   <= 1'b0;
      sticky_right  <= 1'b0;
      sticky_top    <= 1'b0;
      sticky_hazard <= 1'b0;
      start_q       <= 1'b0;
      frame_cnt     <= frame_cnt + 1'b1;
      case (state_q)
        S_RESET: begin
          if (eff_start) begin
            state_q <= S_IDLE;
`ifdef BUMPY_CTRL_LIVES_EN
            lives_q     <= 3'(INIT_LIVES);
            game_over_q <= 1'b0;
`endif
          end
        end
        S_DIE: begin
          // Game over parks in Sdie; only a start request moves it on.
          if (game_over_w) begin
            if (eff_start) state_q <= S_RESET;
          end else if (frame_last) begin
            if (lives_left) begin
              state_q <= S_IDLE;
            end else begin
`ifdef BUMPY_CTRL_LIVES_EN
              game_over_q <= 1'b1;
`endif
            end
          end
        end
        default: begin
          if (eff_hazard) begin
            state_q   <= S_DIE;
            frame_cnt <= '0;
`ifdef BUMPY_CTRL_LIVES_EN
            lives_q   <= lives_left ? (lives_q - 3'd1) : 3'd0;
`endif
          end else if (eff_wall && !in_bounce) begin
            state_q   <= eff_top  ? S_BOUNCE_TOP :
                         eff_left ? S_BOUNCE_LEFT : S_BOUNCE_RIGHT;
            frame_cnt <= '0;
          end else begin
            case (state_q)
              S_IDLE: begin
                if (bus.key_left)       state_q <= S_LEFT;
                else if (bus.key_right) state_q <= S_RIGHT;
                else if (bus.key_up) begin
                  state_q   <= S_UP;
                  frame_cnt <= '0;
                end else if (bus.key_down) begin
                  state_q   <= S_DOWN;
                  frame_cnt <= '0;
                end
              end
              S_LEFT:  if (!bus.key_left)  state_q <= S_IDLE;
              S_RIGHT: if (!bus.key_right) state_q <= S_IDLE;
              S_UP, S_DOWN, S_BOUNCE_LEFT, S_BOUNCE_RIGHT, S_BOUNCE_TOP:
                if (frame_last) state_q <= S_IDLE;
              default: state_q <= S_RESET;
            endcase
          end
        end
      endcase
    end else begin
      sticky_left   <= sticky_left   | bus.coll_left;
      sticky_right  <= sticky_right  | bus.coll_right;
      sticky_top    <= sticky_top    | bus.coll_top;
      sticky_hazard <= sticky_hazard | bus.coll_hazard;
      start_q       <= start_q | (bus.game_start & start_ok);
    end
  end

endmodule

// File: tb/tb_bumpy_state_ctrl.sv
// Directed self-checking bench for bumpy_state_ctrl; lives checks follow
// BUMPY_CTRL_LIVES_EN the same way the design does.
module tb_bumpy_state_ctrl;
  logic clk = 1'b0;
  logic resetN;
  logic startOfFrame;
  int   passed = 0;
  int   total  = 0;

  bumpy_state_ctrl_if bus_if ();

  bumpy_state_ctrl #(
    .BOUNCE_FRAMES (8),
    .DASH_FRAMES   (16),
    .DIE_FRAMES    (30),
    .INIT_LIVES    (3)
  ) dut (
    .clk          (clk),
    .resetN       (resetN),
    .startOfFrame (startOfFrame),
    .bus          (bus_if)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // One frame: collisions are presented only on the startOfFrame clk.
  task automatic frame_with(input logic h, input logic t, input logic l, input logic r);
    bus_if.coll_hazard = h;
    bus_if.coll_top    = t;
    bus_if.coll_left   = l;
    bus_if.coll_right  = r;
    startOfFrame = 1'b1;
    @(negedge clk);
    startOfFrame       = 1'b0;
    bus_if.coll_hazard = 1'b0;
    bus_if.coll_top    = 1'b0;
    bus_if.coll_left   = 1'b0;
    bus_if.coll_right  = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic frame();
    frame_with(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) frame();
  endtask

  task automatic pulse_start();
    bus_if.game_start = 1'b1;
    @(negedge clk);
    bus_if.game_start = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    resetN = 1'b0;
    startOfFrame = 1'b0;
    bus_if.game_start  = 1'b0;
    bus_if.key_left    = 1'b0;
    bus_if.key_right   = 1'b0;
    bus_if.key_up      = 1'b0;
    bus_if.key_down    = 1'b0;
    bus_if.coll_left   = 1'b0;
    bus_if.coll_right  = 1'b0;
    bus_if.coll_top    = 1'b0;
    bus_if.coll_hazard = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_state", 8'(bus_if.state), 8'd0);
    check("reset_lives", 8'(bus_if.lives), 8'd3);
    check("reset_go", 8'(bus_if.game_over), 8'd0);
    resetN = 1'b1;
    @(negedge clk);

    frame();
    check("no_start_stays_reset", 8'(bus_if.state), 8'd0);
    pulse_start();
    frame();
    check("start_idle", 8'(bus_if.state), 8'd1);
    check("start_lives", 8'(bus_if.lives), 8'd3);
    check("start_go", 8'(bus_if.game_over), 8'd0);
    pulse_start();
    frame();
    check("start_ignored_idle", 8'(bus_if.state), 8'd1);

    bus_if.key_left = 1'b1;
    frame();
    check("left_f1", 8'(bus_if.state), 8'd2);
    frame();
    check("left_f2", 8'(bus_if.state), 8'd2);
    frame();
    check("left_f3", 8'(bus_if.state), 8'd2);
    bus_if.key_left = 1'b0;
    frame();
    check("left_release", 8'(bus_if.state), 8'd1);

    bus_if.key_right = 1'b1;
    frame();
    check("right", 8'(bus_if.state), 8'd3);
    bus_if.coll_left = 1'b1;
    @(negedge clk);
    bus_if.coll_left = 1'b0;
    frame();
    check("bounce_left_entry", 8'(bus_if.state), 8'd7);
    bus_if.key_right = 1'b0;
    frames(3);
    bus_if.coll_right = 1'b1;
    @(negedge clk);
    bus_if.coll_right = 1'b0;
    frames(4);
    check("bounce_left_hold7", 8'(bus_if.state), 8'd7);
    frame();
    check("bounce_left_done", 8'(bus_if.state), 8'd1);

    bus_if.key_left  = 1'b1;
    bus_if.key_right = 1'b1;
    frame();
    check("key_prio_left", 8'(bus_if.state), 8'd2);
    bus_if.key_left  = 1'b0;
    bus_if.key_right = 1'b0;
    frame();
    check("key_prio_release", 8'(bus_if.state), 8'd1);

    bus_if.key_up   = 1'b1;
    bus_if.key_down = 1'b1;
    frame();
    check("dash_up", 8'(bus_if.state), 8'd5);
    frames(15);
    check("dash_hold15", 8'(bus_if.state), 8'd5);
    bus_if.key_up   = 1'b0;
    bus_if.key_down = 1'b0;
    frame();
    check("dash_done", 8'(bus_if.state), 8'd1);

    frame_with(1'b0, 1'b1, 1'b1, 1'b1);
    check("wall_prio_top", 8'(bus_if.state), 8'd9);
    frames(7);
    check("bounce_top_hold", 8'(bus_if.state), 8'd9);
    frame();
    check("bounce_top_done", 8'(bus_if.state), 8'd1);
    frame_with(1'b0, 1'b0, 1'b1, 1'b1);
    check("wall_prio_left", 8'(bus_if.state), 8'd7);
    frames(8);
    check("bounce_left2_done", 8'(bus_if.state), 8'd1);

    frame_with(1'b1, 1'b0, 1'b0, 1'b0);
    check("die_entry", 8'(bus_if.state), 8'd6);
`ifdef BUMPY_CTRL_LIVES_EN
    check("die_entry_lives", 8'(bus_if.lives), 8'd2);
`else
    check("die_entry_lives", 8'(bus_if.lives), 8'd3);
`endif
    frames(10);
    bus_if.coll_left = 1'b1;
    @(negedge clk);
    bus_if.coll_left = 1'b0;
    resetN = 1'b0;
    #1;
    check("midreset_state", 8'(bus_if.state), 8'd0);
    check("midreset_lives", 8'(bus_if.lives), 8'd3);
    check("midreset_go", 8'(bus_if.game_over), 8'd0);
    check("midreset_cnt", 8'(dut.frame_cnt), 8'd0);
    @(negedge clk);
    resetN = 1'b1;
    @(negedge clk);
    pulse_start();
    frame();
    check("midreset_no_sticky", 8'(bus_if.state), 8'd1);

`ifdef BUMPY_CTRL_LIVES_EN
    for (int i = 0; i < 3; i++) begin
      frame_with(1'b1, 1'b1, 1'b0, 1'b0);
      check("hazard_entry", 8'(bus_if.state), 8'd6);
      check("hazard_lives", 8'(bus_if.lives), 8'(2 - i));
      frames(29);
      check("die_hold29", 8'(bus_if.state), 8'd6);
      frame();
      check("die_done", 8'(bus_if.state), (i < 2) ? 8'd1 : 8'd6);
      check("die_go", 8'(bus_if.game_over), (i < 2) ? 8'd0 : 8'd1);
    end
    frames(2);
    check("gameover_park", 8'(bus_if.state), 8'd6);
    pulse_start();
    frame();
    check("gameover_to_reset", 8'(bus_if.state), 8'd0);
    check("gameover_lives0", 8'(bus_if.lives), 8'd0);
    pulse_start();
    frame();
    check("restart_idle", 8'(bus_if.state), 8'd1);
    check("restart_lives", 8'(bus_if.lives), 8'd3);
    check("restart_go", 8'(bus_if.game_over), 8'd0);
`else
    for (int i = 0; i < 4; i++) begin
      frame_with(1'b1, 1'b1, 1'b0, 1'b0);
      check("hazard_entry", 8'(bus_if.state), 8'd6);
      check("hazard_lives", 8'(bus_if.lives), 8'd3);
      frames(29);
      check("die_hold29", 8'(bus_if.state), 8'd6);
      frame();
      check("die_done", 8'(bus_if.state), 8'd1);
      check("die_go", 8'(bus_if.game_over), 8'd0);
    end
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
